upcount_8bit: RTL and testbench



---
 rtl/upcount_8bit_pkg.sv | 22 ++
 rtl/upcount_8bit.sv | 33 +++
 tb/tb_upcount_8bit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/upcount_8bit_pkg.sv
// Shared constants and operation decode for the loadable up-counter.
// Load has priority over increment; anything else holds.
package upcount_8bit_pkg;

    localparam int COUNT_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_INC  = 2'd1,
        OP_LOAD = 2'd2
    } count_op_e;

    function automatic count_op_e decode_op(input logic ld, input logic inc);
        if (ld)
            return OP_LOAD;
        else if (inc)
            return OP_INC;
        else
            return OP_HOLD;
    endfunction

endpackage

// File: rtl/upcount_8bit.sv
// Loadable up-counter with asynchronous active-low clear.
// Each rising edge loads data, increments, or holds; q comes straight from the register.
module upcount_8bit
    import upcount_8bit_pkg::*;
#(
    parameter int WIDTH = COUNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             inc,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q
);

    count_op_e op;

    assign op = decode_op(ld, inc);

    // Increment wraps naturally modulo 2**WIDTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else begin
            case (op)
                OP_LOAD: q <= data;
                OP_INC:  q <= q + WIDTH'(1);
                default: q <= q;
            endcase
        end
    end

endmodule

// File: tb/tb_upcount_8bit.sv
// Directed self-checking bench for upcount_8bit: vector table plus
// hand-written async-reset and reset-release sequences.
module tb_upcount_8bit;

    logic       clk;
    logic       rst;
    logic       ld;
    logic       inc;
    logic [7:0] data;
    logic [7:0] q;

    int n_compared = 0;
    int n_failed   = 0;

    upcount_8bit dut (
        .clk  (clk),
        .rst  (rst),
        .ld   (ld),
        .inc  (inc),
        .data (data),
        .q    (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       ld;
        logic       inc;
        logic [7:0] data;
        logic [7:0] exp_q;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: q=%0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic r, input logic l, input logic i,
                       input logic [7:0] d, input logic [7:0] e);
        vec_t v;
        v.name = name; v.rst = r; v.ld = l; v.inc = i; v.data = d; v.exp_q = e;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b0; ld = 1'b0; inc = 1'b0; data = 8'h00;
        #1;
        check("reset_before_edge", q, 8'd0);

        // Expected values below are hand-computed from the counting rules.
        add("reset_held",       1'b0, 1'b0, 1'b1, 8'h00, 8'd0);
        add("reset_ignores_ld", 1'b0, 1'b1, 1'b1, 8'hAA, 8'd0);
        add("load_5",           1'b1, 1'b1, 1'b0, 8'd5,  8'd5);
        add("count_6",          1'b1, 1'b0, 1'b1, 8'd0,  8'd6);
        add("count_7",          1'b1, 1'b0, 1'b1, 8'd0,  8'd7);
        add("count_8",          1'b1, 1'b0, 1'b1, 8'd0,  8'd8);
        add("ld_prio_1",        1'b1, 1'b1, 1'b1, 8'd250, 8'd250);
        add("ld_prio_2",        1'b1, 1'b1, 1'b1, 8'd250, 8'd250);
        add("ld_prio_3",        1'b1, 1'b1, 1'b1, 8'd250, 8'd250);
        add("inc_251",          1'b1, 1'b0, 1'b1, 8'd0,  8'd251);
        add("hold_1",           1'b1, 1'b0, 1'b0, 8'd0,  8'd251);
        add("hold_2",           1'b1, 1'b0, 1'b0, 8'd0,  8'd251);
        add("wrap_252",         1'b1, 1'b0, 1'b1, 8'd0,  8'd252);
        add("wrap_253",         1'b1, 1'b0, 1'b1, 8'd0,  8'd253);
        add("wrap_254",         1'b1, 1'b0, 1'b1, 8'd0,  8'd254);
        add("wrap_255",         1'b1, 1'b0, 1'b1, 8'd0,  8'd255);
        add("wrap_0",           1'b1, 1'b0, 1'b1, 8'd0,  8'd0);
        add("wrap_1",           1'b1, 1'b0, 1'b1, 8'd0,  8'd1);
        add("wrap_2",           1'b1, 1'b0, 1'b1, 8'd0,  8'd2);
        add("track_12",         1'b1, 1'b1, 1'b0, 8'h12, 8'h12);
        add("track_34",         1'b1, 1'b1, 1'b0, 8'h34, 8'h34);
        add("hold_ignores_data",1'b1, 1'b0, 1'b0, 8'hFF, 8'h34);

        foreach (vecs[k]) begin
            @(negedge clk);
            rst = vecs[k].rst; ld = vecs[k].ld; inc = vecs[k].inc; data = vecs[k].data;
            @(posedge clk);
            #1;
            check(vecs[k].name, q, vecs[k].exp_q);
        end

        // Async clear mid-cycle while counting: q must drop with no clock edge.
        @(negedge clk);
        inc = 1'b1; ld = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check("async_clear_no_edge", q, 8'd0);
        ld = 1'b1; data = 8'h77;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check("clear_held", q, 8'd0);
        end

        // First edge after release acts on ld normally.
        @(negedge clk);
        rst = 1'b1; ld = 1'b1; inc = 1'b0; data = 8'd9;
        @(posedge clk);
        #1;
        check("release_load_9", q, 8'd9);
        @(negedge clk);
        ld = 1'b0; inc = 1'b1;
        @(posedge clk);
        #1;
        check("release_inc_10", q, 8'd10);

        // Abort a load in progress: reset asserted just before the edge wins.
        @(negedge clk);
        ld = 1'b1; inc = 1'b0; data = 8'h5A;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_load", q, 8'd0);
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
